// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//
// Round-robin arbiter for the common data bus. Each cycle at most one
// writeback port with a completed result is granted. The grant is
// combinational, and the granted payload is registered onto the CDB one
// cycle later. A flush suppresses the grant, so nothing new reaches the
// CDB in the following cycle.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   flush           pipeline flush: no grant this cycle, rr pointer holds
//   req_valid[i]    writeback port i holds a completed result
//   req_ready[i]    one-hot-or-zero combinational grant
//   req_tag/preg/writes_rd/data/exc[i]   payload of port i
//   cdb_valid       CDB carries a completion this cycle
//   cdb_tag/preg/writes_rd/data/exc      broadcast payload (held when idle)
//   conflict_cnt    saturating count of unflushed cycles with >=2 requesters
module cdb_arbiter #(
  parameter int NUM_REQ  = 4,
  // Design-wide ROB depth; TAG_W follows from it unless overridden.
  parameter int ROB_SIZE = 32,
  parameter int TAG_W    = $clog2(ROB_SIZE),
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]  req_preg,
  input  logic [NUM_REQ-1:0]              req_writes_rd,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]              req_exc,
  output logic                            cdb_valid,
  output logic [TAG_W-1:0]                cdb_tag,
  output logic [PREG_W-1:0]               cdb_preg,
  output logic                            cdb_writes_rd,
  output logic [DATA_W-1:0]               cdb_data,
  output logic                            cdb_exc,
  output logic [15:0]                     conflict_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_next;
  logic [PTR_W-1:0] gnt_idx;
  logic             grant_any;
  logic             multi_req;

  // Walk the requesters starting at rr_ptr. The index wraps explicitly at
  // NUM_REQ-1 so a non-power-of-two port count never visits a missing port.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    idx     = rr_ptr;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
      idx = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
    end
    // No handshake may complete during flush or while the arbiter is held
    // in reset; otherwise a requester would drop a result that never lands.
    grant_any = found && !flush && rst_n;
  end

  // Two or more valid requesters in the same cycle.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    multi_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (seen) begin
          multi_req = 1'b1;
        end
        seen = 1'b1;
      end
    end
  end

  assign rr_ptr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_any && (gnt_idx == PTR_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      cdb_valid     <= 1'b0;
      cdb_tag       <= '0;
      cdb_preg      <= '0;
      cdb_writes_rd <= 1'b0;
      cdb_data      <= '0;
      cdb_exc       <= 1'b0;
      conflict_cnt  <= '0;
    end else begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        rr_ptr        <= rr_ptr_next;
        cdb_tag       <= req_tag[gnt_idx];
        cdb_preg      <= req_preg[gnt_idx];
        cdb_writes_rd <= req_writes_rd[gnt_idx];
        cdb_data      <= req_data[gnt_idx];
        cdb_exc       <= req_exc[gnt_idx];
      end
      if (multi_req && !flush && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter (NUM_REQ=4, TAG_W=5, PREG_W=6, DATA_W=32).
// Each requester carries a fixed payload from small constant tables; the
// expected grant sequence and counter values are worked out by hand below.
module tb_cdb_arbiter;

  localparam int NR = 4;
  localparam int TW = 5;
  localparam int PW = 6;
  localparam int DW = 32;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][TW-1:0]  req_tag;
  logic [NR-1:0][PW-1:0]  req_preg;
  logic [NR-1:0]          req_writes_rd;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0]          req_exc;
  logic                   cdb_valid;
  logic [TW-1:0]          cdb_tag;
  logic [PW-1:0]          cdb_preg;
  logic                   cdb_writes_rd;
  logic [DW-1:0]          cdb_data;
  logic                   cdb_exc;
  logic [15:0]            conflict_cnt;

  logic [TW-1:0] tag_tbl  [NR];
  logic [PW-1:0] preg_tbl [NR];
  logic [DW-1:0] data_tbl [NR];
  logic [NR-1:0] wr_tbl;

  int total;
  int bad;

  cdb_arbiter #(
    .NUM_REQ(NR), .ROB_SIZE(32), .TAG_W(TW), .PREG_W(PW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_preg(req_preg), .req_writes_rd(req_writes_rd),
    .req_data(req_data), .req_exc(req_exc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_preg(cdb_preg),
    .cdb_writes_rd(cdb_writes_rd), .cdb_data(cdb_data), .cdb_exc(cdb_exc),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request pattern, check the combinational grant, take the edge.
  task automatic step(input string name, input logic [NR-1:0] valid,
                      input logic fl, input logic [NR-1:0] exp_ready);
    req_valid = valid;
    flush     = fl;
    #1;
    check({name, "_ready"}, 64'(req_ready), 64'(exp_ready));
    tick();
  endtask

  // CDB must carry requester g's payload.
  task automatic expect_cdb(input string name, input int g);
    check({name, "_cdb_valid"}, 64'(cdb_valid), 64'(1'b1));
    check({name, "_cdb_tag"},   64'(cdb_tag),   64'(tag_tbl[g]));
    check({name, "_cdb_preg"},  64'(cdb_preg),  64'(preg_tbl[g]));
    check({name, "_cdb_data"},  64'(cdb_data),  64'(data_tbl[g]));
    check({name, "_cdb_wr"},    64'(cdb_writes_rd), 64'(wr_tbl[g]));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tag_tbl  = '{5'd1, 5'd3, 5'd5, 5'd7};
    preg_tbl = '{6'd20, 6'd33, 6'd12, 6'd40};
    data_tbl = '{32'hA000_0000, 32'hA000_0001, 32'hDEAD_BEEF, 32'hA000_0003};
    wr_tbl   = 4'b1101;
    for (int i = 0; i < NR; i++) begin
      req_tag[i]  = tag_tbl[i];
      req_preg[i] = preg_tbl[i];
      req_data[i] = data_tbl[i];
    end
    req_writes_rd = wr_tbl;
    req_exc       = '0;
    req_valid     = '0;
    flush         = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    #2;
    check("rst_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    check("rst_cdb_tag",   64'(cdb_tag),   64'(0));
    check("rst_cdb_preg",  64'(cdb_preg),  64'(0));
    check("rst_cdb_data",  64'(cdb_data),  64'(0));
    check("rst_cdb_wr",    64'(cdb_writes_rd), 64'(0));
    check("rst_cdb_exc",   64'(cdb_exc),   64'(0));
    check("rst_conflict",  64'(conflict_cnt), 64'(0));
    check("rst_ready",     64'(req_ready), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;

    // Single requester 2: grant same cycle, CDB next cycle; rr_ptr -> 3
    step("single", 4'b0100, 1'b0, 4'b0100);
    req_valid = '0;
    expect_cdb("single", 2);
    check("single_conflict", 64'(conflict_cnt), 64'(0));
    step("idle", 4'b0000, 1'b0, 4'b0000);
    check("idle_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    check("idle_cdb_tag_hold", 64'(cdb_tag), 64'(5));

    // Wrap with gaps from rr_ptr=3
    step("wrap_a", 4'b0011, 1'b0, 4'b0001);   // ptr 3 -> grant 0, ptr 1
    expect_cdb("wrap_a", 0);
    check("wrap_a_conflict", 64'(conflict_cnt), 64'(1));
    step("wrap_b", 4'b0011, 1'b0, 4'b0010);   // ptr 1 -> grant 1, ptr 2
    expect_cdb("wrap_b", 1);
    step("wrap_c", 4'b1001, 1'b0, 4'b1000);   // ptr 2 -> grant 3, ptr 0
    expect_cdb("wrap_c", 3);
    step("wrap_d", 4'b0001, 1'b0, 4'b0001);   // ptr 0 -> grant 0, ptr 1
    expect_cdb("wrap_d", 0);
    check("wrap_d_conflict", 64'(conflict_cnt), 64'(3));

    // Flush: no grant, CDB drops next cycle, ptr (1) holds, no conflict count
    req_valid = 4'b0001;
    flush     = 1'b1;
    #1;
    check("flush_ready", 64'(req_ready), 64'(0));
    check("flush_old_cdb_visible", 64'(cdb_valid), 64'(1'b1));
    tick();
    check("flush_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    step("flush2", 4'b0011, 1'b1, 4'b0000);
    check("flush2_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    check("flush2_conflict", 64'(conflict_cnt), 64'(3));
    step("post_flush", 4'b0011, 1'b0, 4'b0010); // ptr still 1 -> grant 1
    expect_cdb("post_flush", 1);
    check("post_flush_conflict", 64'(conflict_cnt), 64'(4));
    step("post_flush0", 4'b0001, 1'b0, 4'b0001);
    expect_cdb("post_flush0", 0);

    // Asynchronous reset while cdb_valid=1
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    check("midrst_conflict",  64'(conflict_cnt), 64'(0));
    check("midrst_cdb_tag",   64'(cdb_tag), 64'(0));
    req_valid = 4'b1010;
    tick();
    check("inrst_cdb_valid", 64'(cdb_valid), 64'(1'b0));
    rst_n = 1'b1;
    step("after_rst", 4'b1010, 1'b0, 4'b0010);  // lowest valid index first
    expect_cdb("after_rst", 1);
    check("after_rst_conflict", 64'(conflict_cnt), 64'(1));

    // All requesters valid from rr_ptr=0 (fresh reset): 0,1,2,3,0,1,2,3
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step("all", 4'b1111, 1'b0, 4'(1 << (k % 4)));
      expect_cdb("all", k % 4);
    end
    check("all_conflict", 64'(conflict_cnt), 64'(8));

    // Saturation: 8 + 65540 conflict cycles clamps at FFFF
    req_valid = 4'b0011;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_conflict", 64'(conflict_cnt), 64'(16'hFFFF));
    step("sat_more", 4'b0011, 1'b0, 4'b0001);   // 65540 alternating grants end at 1 -> ptr 2
    check("sat_hold", 64'(conflict_cnt), 64'(16'hFFFF));
    step("pre_exc", 4'b0000, 1'b0, 4'b0000);

    // Exception passthrough
    req_exc = 4'b0001;
    step("exc", 4'b0001, 1'b0, 4'b0001);
    expect_cdb("exc", 0);
    check("exc_cdb_exc", 64'(cdb_exc), 64'(1'b1));
    step("noexc", 4'b0010, 1'b0, 4'b0010);
    expect_cdb("noexc", 1);
    check("noexc_cdb_exc", 64'(cdb_exc), 64'(1'b0));
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the functional-unit writeback ports. Each cycle it grants at most one completing unit. It registers that unit's ROB tag, destination physical register and result onto the CDB, where the ROB marks the entry done and the reservation stations wake up. It sits between the execute-stage writeback ports and the ROB/RS completion inputs, and it drops in-flight results on a pipeline flush.

## Interface
- NUM_REQ, default 4: number of requesting writeback ports, ≥2; need not be a power of 2.
- TAG_W, default $clog2(ROB_SIZE): ROB tag width, with ROB_SIZE taken from cpu_design_params.
- PREG_W, default 6: physical register index width.
- DATA_W, default 32: result width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush; discards the pending grant and the CDB output.
- req_valid  in  [NUM_REQ]  requester i holds a completed result.
- req_ready  out  [NUM_REQ]  one-hot-or-zero combinational grant.
- req_tag  in  [NUM_REQ][TAG_W]  ROB tag of requester i.
- req_preg  in  [NUM_REQ][PREG_W]  destination physical register.
- req_writes_rd  in  [NUM_REQ]  result writes a register.
- req_data  in  [NUM_REQ][DATA_W]  result value.
- req_exc  in  [NUM_REQ]  result raised an exception.
- cdb_valid  out  1  CDB carries a completion this cycle.
- cdb_tag  out  TAG_W  broadcast ROB tag.
- cdb_preg  out  PREG_W  broadcast physical register.
- cdb_writes_rd  out  1  broadcast write-enable for the PRF and RS wakeup.
- cdb_data  out  DATA_W  broadcast result.
- cdb_exc  out  1  broadcast exception flag; the ROB sets the entry's exception bit.
- conflict_cnt  out  16  saturating count of cycles with ≥2 valid requesters.

## Operation
- **Priority pointer.** rr_ptr, range 0..NUM_REQ-1, names the highest-priority requester. The search order is rr_ptr, rr_ptr+1, … with modulo-NUM_REQ wrap.
- **Grant.** The grant goes to the first i in search order with req_valid[i]=1. Only that requester sees req_ready[i]=1; all other req_ready bits are 0.
- **No valid requester.** If req_valid is all zero, req_ready is all zero and rr_ptr holds.
- **Flush cycle.** When flush=1, req_ready is forced to all zero, no grant occurs and rr_ptr holds.
- **Pointer advance.** On a grant to g, rr_ptr ← (g==NUM_REQ-1) ? 0 : g+1. The wrap is explicit, not implied by bit width.
- **Handshake.** A transfer occurs when req_valid[i] && req_ready[i]. A requester holds its valid and payload stable until it is granted. The arbiter assumes requesters never drop valid before the grant.
- **CDB output register.**
  - On a grant, cdb_valid ← 1 and the cdb_* fields ← the granted payload.
  - Otherwise cdb_valid ← 0 and the cdb_* fields hold their last value.
- **No backpressure.** The CDB is a pure broadcast.
- **Conflict counter.** conflict_cnt increments in any cycle where popcount(req_valid) ≥ 2 and flush=0. It saturates at 16'hFFFF.

## Timing
- **Reset values.** While rst_n=0 (asynchronous): rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_preg=0, cdb_writes_rd=0, cdb_data=0, cdb_exc=0, conflict_cnt=0. req_ready is combinational and is 0 whenever req_valid=0.
- **Latency.** The grant is in the same cycle as the request (combinational from req_valid, rr_ptr and flush). The result appears on the CDB exactly 1 cycle after the handshake.
- **Throughput.** One completion per cycle. Back-to-back grants to the same requester are allowed only if no other requester is valid.
- **Fairness bound.** A continuously valid requester is granted within NUM_REQ cycles.
- **Flush registered.** When flush=1 at an edge, cdb_valid=0 the next cycle, even if a grant would otherwise have occurred. A CDB output already valid in the flush cycle is still seen in that cycle; the ROB ignores it during flush.
- **Reset mid-operation.** Pending requests are lost from the arbiter's view, and the CDB drops immediately (asynchronously). The first post-reset grant goes to the lowest valid index.

## Test plan
- **Single requester.** Reset, then hold req_valid=4'b0100 with tag=5, preg=12, data=32'hDEAD_BEEF for 1 cycle. Required: req_ready=4'b0100 in the same cycle; the next cycle shows cdb_valid=1, cdb_tag=5, cdb_preg=12, cdb_data=32'hDEAD_BEEF; rr_ptr=3.
- **All requesters valid.** Hold req_valid=4'b1111 for 8 cycles with rr_ptr=0. Required: grants go 0,1,2,3,0,1,2,3 on successive cycles; cdb_valid=1 on every cycle from 1 to 8; conflict_cnt=8.
- **Wrap with gaps.** With rr_ptr=3, present req_valid=4'b0011. Required: grant to 0, then rr_ptr=1, then grant to 1; requester 3 is never skipped when it later asserts.
- **Flush.** Assert flush together with req_valid=4'b0001. Required: req_ready=0, the next cycle has cdb_valid=0, rr_ptr is unchanged. After flush deasserts, requester 0 is granted.
- **Reset mid-stream.** Drop rst_n asynchronously while cdb_valid=1. Required: cdb_valid=0 and conflict_cnt=0 immediately. After rst_n rises with req_valid=4'b1010, the grant goes to 1.
- **Saturation and exception passthrough.** Preload conflict_cnt near its limit by running 65 540 cycles with two requesters valid. Required: conflict_cnt=16'hFFFF. A granted req_exc=1 appears as cdb_exc=1 one cycle later.
